// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline slice.
// Contents:
//   - datapath widths (data word, register index, ALUOp)
//   - opcode constants for the instruction classes the decoder emits
//   - ALUOp encodings
//   - the ID/EX control bundle (CTRL_W bits) as a packed struct
package mips_pkg;

  localparam int DATA_W    = 32;
  localparam int REG_IDX_W = 5;
  localparam int ALUOP_W   = 2;
  localparam int CTRL_W    = 9;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

  // Seven single-bit decoder outputs plus ALUOp; a bubble is simply '0.
  typedef struct packed {
    logic               regdst;
    logic               branch;
    logic               memread;
    logic               memtoreg;
    logic               memwrite;
    logic               alusrc;
    logic               regwrite;
    logic [ALUOP_W-1:0] aluop;
  } ctrl_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector (purely combinational).
// Flags when the instruction in EX is a valid load whose destination (rt,
// non-zero) is read by the valid instruction in ID, unless ID is being
// flushed.
// Ports:
//   i_ex_valid, i_ex_memread, i_ex_rt : registered EX-stage fields
//   i_id_valid, i_id_rs, i_id_rt      : ID-stage instruction fields
//   i_flush                           : ID instruction is being killed
//   o_hazard_stall                    : hold PC and IF/ID, bubble EX
module hazard_detect
  import mips_pkg::*;
(
  input  logic                 i_ex_valid,
  input  logic                 i_ex_memread,
  input  logic [REG_IDX_W-1:0] i_ex_rt,
  input  logic                 i_id_valid,
  input  logic                 i_flush,
  input  logic [REG_IDX_W-1:0] i_id_rs,
  input  logic [REG_IDX_W-1:0] i_id_rt,
  output logic                 o_hazard_stall
);

  logic w_load_in_ex;
  logic w_rt_match;

  assign w_load_in_ex = i_ex_valid & i_ex_memread & (i_ex_rt != '0);
  // rt is compared even when ID holds lw/sw; the extra stall is accepted.
  assign w_rt_match   = (i_ex_rt == i_id_rs) | (i_ex_rt == i_id_rt);

  assign o_hazard_stall = w_load_in_ex & w_rt_match & i_id_valid & ~i_flush;

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use bubble insertion.
// Captures decoder control bits and operand data for EX each cycle.
// Update priority: flush (bubble) > hold (freeze) > hazard (bubble) > load.
// Ports:
//   clk, reset                : clock, asynchronous active-high reset
//   id_valid, id_<ctrl>       : decoder outputs for the instruction in ID
//   id_pc4/rd1/rd2/imm        : 32-bit operand data
//   id_rs/rt/rd               : register indices
//   flush, hold               : branch-taken kill, global freeze
//   ex_*                      : registered copies of the id_* fields
//   ex_valid                  : EX holds a real instruction
//   hazard_stall              : combinational stall request to PC / IF/ID
module id_ex_pipe
  import mips_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic                 id_regdst,
  input  logic                 id_branch,
  input  logic                 id_memread,
  input  logic                 id_memtoreg,
  input  logic                 id_memwrite,
  input  logic                 id_alusrc,
  input  logic                 id_regwrite,
  input  logic [ALUOP_W-1:0]   id_aluop,
  input  logic [DATA_W-1:0]    id_pc4,
  input  logic [DATA_W-1:0]    id_rd1,
  input  logic [DATA_W-1:0]    id_rd2,
  input  logic [DATA_W-1:0]    id_imm,
  input  logic [REG_IDX_W-1:0] id_rs,
  input  logic [REG_IDX_W-1:0] id_rt,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic                 flush,
  input  logic                 hold,
  output logic                 ex_regdst,
  output logic                 ex_branch,
  output logic                 ex_memread,
  output logic                 ex_memtoreg,
  output logic                 ex_memwrite,
  output logic                 ex_alusrc,
  output logic                 ex_regwrite,
  output logic [ALUOP_W-1:0]   ex_aluop,
  output logic [DATA_W-1:0]    ex_pc4,
  output logic [DATA_W-1:0]    ex_rd1,
  output logic [DATA_W-1:0]    ex_rd2,
  output logic [DATA_W-1:0]    ex_imm,
  output logic [REG_IDX_W-1:0] ex_rs,
  output logic [REG_IDX_W-1:0] ex_rt,
  output logic [REG_IDX_W-1:0] ex_rd,
  output logic                 ex_valid,
  output logic                 hazard_stall
);

  ctrl_t                w_id_ctrl;
  logic                 w_stall;
  ctrl_t                r_ctrl;
  logic                 r_valid;
  logic [DATA_W-1:0]    r_pc4, r_rd1, r_rd2, r_imm;
  logic [REG_IDX_W-1:0] r_rs, r_rt, r_rd;

  // Invalid ID slots carry no control, so decoder X never reaches EX.
  assign w_id_ctrl = id_valid ? ctrl_t'{regdst:   id_regdst,
                                        branch:   id_branch,
                                        memread:  id_memread,
                                        memtoreg: id_memtoreg,
                                        memwrite: id_memwrite,
                                        alusrc:   id_alusrc,
                                        regwrite: id_regwrite,
                                        aluop:    id_aluop}
                              : ctrl_t'('0);

  hazard_detect u_hazard_detect (
    .i_ex_valid     (r_valid),
    .i_ex_memread   (r_ctrl.memread),
    .i_ex_rt        (r_rt),
    .i_id_valid     (id_valid),
    .i_flush        (flush),
    .i_id_rs        (id_rs),
    .i_id_rt        (id_rt),
    .o_hazard_stall (w_stall)
  );

  // ID -> EX register stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl  <= '0;
      r_valid <= 1'b0;
      r_pc4   <= '0;
      r_rd1   <= '0;
      r_rd2   <= '0;
      r_imm   <= '0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_rd    <= '0;
    end else if (flush || !hold) begin
      // Data always follows ID when not frozen; only control is bubbled.
      r_pc4 <= id_pc4;
      r_rd1 <= id_rd1;
      r_rd2 <= id_rd2;
      r_imm <= id_imm;
      r_rs  <= id_rs;
      r_rt  <= id_rt;
      r_rd  <= id_rd;
      if (flush || w_stall) begin
        r_ctrl  <= '0;
        r_valid <= 1'b0;
      end else begin
        r_ctrl  <= w_id_ctrl;
        r_valid <= id_valid;
      end
    end
  end

  assign ex_regdst    = r_ctrl.regdst;
  assign ex_branch    = r_ctrl.branch;
  assign ex_memread   = r_ctrl.memread;
  assign ex_memtoreg  = r_ctrl.memtoreg;
  assign ex_memwrite  = r_ctrl.memwrite;
  assign ex_alusrc    = r_ctrl.alusrc;
  assign ex_regwrite  = r_ctrl.regwrite;
  assign ex_aluop     = r_ctrl.aluop;
  assign ex_pc4       = r_pc4;
  assign ex_rd1       = r_rd1;
  assign ex_rd2       = r_rd2;
  assign ex_imm       = r_imm;
  assign ex_rs        = r_rs;
  assign ex_rt        = r_rt;
  assign ex_rd        = r_rd;
  assign ex_valid     = r_valid;
  assign hazard_stall = w_stall;

endmodule

// File: tb/tb_id_ex_pipe.sv
module tb_id_ex_pipe;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        id_valid, id_regdst, id_branch, id_memread, id_memtoreg;
  logic        id_memwrite, id_alusrc, id_regwrite;
  logic [1:0]  id_aluop;
  logic [31:0] id_pc4, id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        flush, hold;
  logic        ex_regdst, ex_branch, ex_memread, ex_memtoreg, ex_memwrite;
  logic        ex_alusrc, ex_regwrite;
  logic [1:0]  ex_aluop;
  logic [31:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic        ex_valid, hazard_stall;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  id_ex_pipe dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_regdst(id_regdst), .id_branch(id_branch), .id_memread(id_memread),
    .id_memtoreg(id_memtoreg), .id_memwrite(id_memwrite),
    .id_alusrc(id_alusrc), .id_regwrite(id_regwrite), .id_aluop(id_aluop),
    .id_pc4(id_pc4), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .flush(flush), .hold(hold),
    .ex_regdst(ex_regdst), .ex_branch(ex_branch), .ex_memread(ex_memread),
    .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite),
    .ex_alusrc(ex_alusrc), .ex_regwrite(ex_regwrite), .ex_aluop(ex_aluop),
    .ex_pc4(ex_pc4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_valid(ex_valid), .hazard_stall(hazard_stall)
  );

  always #5 clk = ~clk;

  // Reference model: EX-stage contents as plain fields.
  // ctrl bit order: regdst,branch,memread,memtoreg,memwrite,alusrc,regwrite
  logic [6:0]  m_ctrl;
  logic [1:0]  m_aluop;
  logic        m_valid;
  logic [31:0] m_pc4, m_rd1, m_rd2, m_imm;
  logic [4:0]  m_rs, m_rt, m_rd;

  initial begin
    m_ctrl = '0; m_aluop = '0; m_valid = 0;
    m_pc4 = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0;
    m_rs = '0; m_rt = '0; m_rd = '0;
  end

  function automatic bit model_stall();
    return m_valid && m_ctrl[4] && id_valid && !flush && m_rt != 5'd0 &&
           (m_rt == id_rs || m_rt == id_rt);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ctrl = '0; m_aluop = '0; m_valid = 0;
      m_pc4 = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0;
      m_rs = '0; m_rt = '0; m_rd = '0;
    end else begin
      bit bubble, keep;
      bubble = flush || (!hold && model_stall());
      keep   = !flush && hold;
      if (!keep) begin
        m_pc4 = id_pc4; m_rd1 = id_rd1; m_rd2 = id_rd2; m_imm = id_imm;
        m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
        if (bubble || !id_valid) begin
          m_ctrl = '0; m_aluop = '0; m_valid = bubble ? 1'b0 : id_valid;
        end else begin
          m_ctrl  = {id_regdst, id_branch, id_memread, id_memtoreg,
                     id_memwrite, id_alusrc, id_regwrite};
          m_aluop = id_aluop;
          m_valid = 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_ctrl", {25'd0, ex_regdst, ex_branch, ex_memread, ex_memtoreg,
                       ex_memwrite, ex_alusrc, ex_regwrite}, {25'd0, m_ctrl});
      check("m_aluop", {30'd0, ex_aluop}, {30'd0, m_aluop});
      check("m_valid", {31'd0, ex_valid}, {31'd0, m_valid});
      check("m_pc4", ex_pc4, m_pc4);
      check("m_rd1", ex_rd1, m_rd1);
      check("m_rd2", ex_rd2, m_rd2);
      check("m_imm", ex_imm, m_imm);
      check("m_idx", {17'd0, ex_rs, ex_rt, ex_rd}, {17'd0, m_rs, m_rt, m_rd});
      check("m_stall", {31'd0, hazard_stall}, {31'd0, model_stall()});
    end
  end

  task automatic idle();
    id_valid = 0; id_regdst = 0; id_branch = 0; id_memread = 0;
    id_memtoreg = 0; id_memwrite = 0; id_alusrc = 0; id_regwrite = 0;
    id_aluop = ALUOP_ADD; id_pc4 = '0; id_rd1 = '0; id_rd2 = '0; id_imm = '0;
    id_rs = '0; id_rt = '0; id_rd = '0; flush = 0; hold = 0;
  endtask

  task automatic rtype(input logic [4:0] rd, rs, rt,
                       input logic [31:0] a, b);
    idle();
    id_valid = 1; id_regdst = 1; id_regwrite = 1; id_aluop = ALUOP_FUNCT;
    id_rs = rs; id_rt = rt; id_rd = rd; id_rd1 = a; id_rd2 = b;
    id_pc4 = 32'h100;
  endtask

  task automatic lw(input logic [4:0] rt, rs, input logic [31:0] off);
    idle();
    id_valid = 1; id_memread = 1; id_memtoreg = 1; id_alusrc = 1;
    id_regwrite = 1; id_aluop = ALUOP_ADD; id_rs = rs; id_rt = rt;
    id_imm = off; id_pc4 = 32'h200;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    idle();
    #1 reset = 1'b1;
    step(); step();
    reset = 1'b0;
    chk_en = 1'b1;

    // Reset in the middle of a cycle while EX holds a writing instruction.
    rtype(5'd3, 5'd1, 5'd2, 32'h5, 32'h7);
    step();
    check("pre_reset_regwrite", {31'd0, ex_regwrite}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("reset_regwrite", {31'd0, ex_regwrite}, 32'd0);
    check("reset_valid", {31'd0, ex_valid}, 32'd0);
    check("reset_rd1", ex_rd1, 32'd0);
    check("reset_stall", {31'd0, hazard_stall}, 32'd0);
    step();
    reset = 1'b0;

    // Plain R-type.
    rtype(5'd3, 5'd1, 5'd2, 32'h5, 32'h7);
    #1 check("rtype_stall", {31'd0, hazard_stall}, 32'd0);
    step();
    check("rtype_regdst", {31'd0, ex_regdst}, 32'd1);
    check("rtype_aluop", {30'd0, ex_aluop}, 32'd2);
    check("rtype_rd1", ex_rd1, 32'h5);
    check("rtype_valid", {31'd0, ex_valid}, 32'd1);

    // Load-use: lw r1,4(r2); add r4,r1,r5.
    lw(5'd1, 5'd2, 32'd4);
    step();
    rtype(5'd4, 5'd1, 5'd5, 32'h11, 32'h22);
    #1 check("lu_stall_on", {31'd0, hazard_stall}, 32'd1);
    step();
    check("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    check("lu_bubble_memread", {31'd0, ex_memread}, 32'd0);
    check("lu_bubble_regwrite", {31'd0, ex_regwrite}, 32'd0);
    #1 check("lu_stall_off", {31'd0, hazard_stall}, 32'd0);
    step();
    check("lu_add_valid", {31'd0, ex_valid}, 32'd1);
    check("lu_add_rd", {27'd0, ex_rd}, 32'd4);

    // r0 destination never stalls.
    lw(5'd0, 5'd2, 32'd8);
    step();
    rtype(5'd4, 5'd0, 5'd5, 32'h1, 32'h2);
    #1 check("r0_stall", {31'd0, hazard_stall}, 32'd0);
    step();

    // Flush wins over a load-use hazard.
    lw(5'd1, 5'd2, 32'd4);
    step();
    rtype(5'd4, 5'd1, 5'd5, 32'h1, 32'h2);
    flush = 1;
    #1 check("flush_stall", {31'd0, hazard_stall}, 32'd0);
    step();
    check("flush_valid", {31'd0, ex_valid}, 32'd0);
    check("flush_regwrite", {31'd0, ex_regwrite}, 32'd0);

    // Hold freezes EX while the hazard stays asserted.
    lw(5'd1, 5'd2, 32'd4);
    step();
    rtype(5'd4, 5'd1, 5'd5, 32'h1, 32'h2);
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      #1 check("hold_stall", {31'd0, hazard_stall}, 32'd1);
      step();
      check("hold_memread", {31'd0, ex_memread}, 32'd1);
      check("hold_imm", ex_imm, 32'd4);
      id_rd1 = $urandom; id_rd2 = $urandom; id_pc4 = $urandom;
    end
    hold = 0;
    step();
    check("hold_rel_bubble", {31'd0, ex_valid}, 32'd0);
    step();
    check("hold_rel_add", {31'd0, ex_regwrite & ex_valid}, 32'd1);

    // Back-to-back loads: lw r1; lw r2,0(r1).
    lw(5'd1, 5'd2, 32'd4);
    step();
    lw(5'd2, 5'd1, 32'd0);
    #1 check("b2b_stall", {31'd0, hazard_stall}, 32'd1);
    step(); step();
    check("b2b_second", {31'd0, ex_memread & ex_valid}, 32'd1);

    // Randomized traffic with a small register set to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      id_valid    = ($urandom_range(0, 3) != 0);
      id_regdst   = $urandom; id_branch = $urandom;
      id_memread  = ($urandom_range(0, 2) == 0);
      id_memtoreg = $urandom; id_memwrite = $urandom;
      id_alusrc   = $urandom; id_regwrite = $urandom;
      id_aluop    = 2'($urandom);
      id_pc4 = $urandom; id_rd1 = $urandom; id_rd2 = $urandom;
      id_imm = $urandom;
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      id_rd = 5'($urandom);
      flush = ($urandom_range(0, 9) == 0);
      hold  = ($urandom_range(0, 5) == 0);
      reset = ($urandom_range(0, 149) == 0);
      step();
    end
    reset = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
